inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of line count (64 direct-mapped one-word lines).
REQ-002 SHALL have parameter ADDR_BITS, default 32, meaning byte-address width; tag = addr[ADDR_BITS-1:INDEX_BITS+2].
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have port clr  input  1  pipeline flush (branch mispredict), synchronous.
REQ-007 SHALL have port if_req  input  1  fetcher requests an instruction.
REQ-008 SHALL have port if_addr  input  ADDR_BITS  fetch PC, word-aligned.
REQ-009 SHALL have port if_valid  output  1  if_inst valid this cycle, one-cycle pulse.
REQ-010 SHALL have port if_inst  output  32  fetched instruction word.
REQ-011 SHALL have port mc_req  output  1  word-fetch request to memory controller.
REQ-012 SHALL have port mc_addr  output  ADDR_BITS  word address of the miss.
REQ-013 SHALL have port mc_done  input  1  memory controller returns the word, one-cycle pulse.
REQ-014 SHALL have port mc_data  input  32  returned word, little-endian assembled by the controller.

Function
REQ-015 SHALL store per line: valid bit, tag, 32-bit data; no write path from the core.
REQ-016 SHALL implement FSM states IDLE and MISS.
REQ-017 IDLE, if_req=1, line valid and tag match: SHALL assert if_valid=1 with if_inst=line data on the next edge (hit latency 1 cycle), stay IDLE.
REQ-018 IDLE, if_req=1, miss: SHALL latch if_addr, set mc_req=1 and mc_addr=latched addr on the next edge, go MISS; if_valid stays 0.
REQ-019 MISS: SHALL hold mc_req=1 and mc_addr stable until mc_done; if_req/if_addr ignored.
REQ-020 MISS, mc_done=1: on that edge SHALL write line (valid=1, tag, mc_data), drive if_valid=1, if_inst=mc_data, mc_req=0, go IDLE.
REQ-021 Fetcher holds if_req/if_addr stable until if_valid; a new lookup SHALL start only in IDLE, so one outstanding miss max.
REQ-022 if_valid SHALL be high for exactly one cycle per completed request; low otherwise.
REQ-023 clr=1 (with rdy=1): on the edge SHALL go IDLE, mc_req=0, if_valid=0; no lookup accepted that cycle; cache contents retained.
REQ-024 clr and mc_done same cycle: clr wins; returned word SHALL NOT be written and SHALL NOT be presented.
REQ-025 rdy=0: SHALL hold all registers and outputs unchanged (mc_done ignored; controller also frozen under rdy).
REQ-026 Index = addr[INDEX_BITS+1:2]; conflicting addresses SHALL evict the previous line on fill.
REQ-027 addr[1:0] SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately clear all valid bits, FSM to IDLE, if_valid=0, if_inst=0, mc_req=0, mc_addr=0, independent of clk and rdy.
REQ-029 Reset asserted during MISS SHALL abandon the fetch; no fill after deassertion.
REQ-030 First edge after rst deasserts SHALL be a normal IDLE cycle.

Verification
REQ-031 Cold miss: reset, if_req=1 addr=0x0000_0004 -> mc_req=1 mc_addr=0x4 next cycle; mc_done with 0x0000_0013 three cycles later -> if_valid=1, if_inst=0x13 same edge, mc_req=0.
REQ-032 Hit: repeat addr 0x4 -> if_valid=1 if_inst=0x13 one cycle after if_req, mc_req stays 0.
REQ-033 Conflict: fill 0x4, then addr 0x104 (same index, different tag) -> miss, mc_addr=0x104; then 0x4 -> miss again.
REQ-034 Flush: miss on 0x8, clr pulse in cycle 2 of MISS -> mc_req=0 next edge, no if_valid; later mc_done pulse ignored; re-request 0x8 -> miss.
REQ-035 clr and mc_done coincident for addr 0xC -> no if_valid, re-request 0xC misses.
REQ-036 rdy held low 5 cycles mid-MISS with mc_done pulsed -> no state change; rst=0 mid-MISS -> outputs zero asynchronously, prior hit address now misses.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// A lookup is accepted only in the idle state. A hit returns the word one cycle later.
// A miss issues one word fetch to the memory controller and holds it until the word
// comes back. The returned word is then written into the line and passed to the
// fetcher on the same edge.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rdy       global enable; low freezes every register
//   clr       synchronous pipeline flush; abandons any outstanding miss
//   if_req    fetcher lookup request, held until if_valid
//   if_addr   fetch PC (byte address, bits [1:0] ignored)
//   if_valid  one-cycle pulse: if_inst holds the requested word
//   if_inst   fetched instruction word
//   mc_req    word-fetch request to the memory controller
//   mc_addr   word-aligned address of the outstanding miss
//   mc_done   one-cycle pulse: mc_data holds the returned word
//   mc_data   returned word
module inst_cache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic                 if_valid,
  output logic [31:0]          if_inst,
  output logic                 mc_req,
  output logic [ADDR_BITS-1:0] mc_addr,
  input  logic                 mc_done,
  input  logic [31:0]          mc_data
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic {StIdle, StMiss} state_e;

  state_e                 state_q;
  logic                   if_valid_q;
  logic [31:0]            if_inst_q;
  logic                   mc_req_q;
  logic [ADDR_BITS-1:0]   mc_addr_q;

  logic [Lines-1:0]       valid_q;
  logic [TagBits-1:0]     tag_q  [Lines];
  logic [31:0]            data_q [Lines];

  logic [INDEX_BITS-1:0]  req_index;
  logic [TagBits-1:0]     req_tag;
  logic                   req_hit;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [TagBits-1:0]     fill_tag;
  logic                   fill_en;
  logic                   unused_addr_bits;

  // Byte offset within the word never affects the lookup.
  assign unused_addr_bits = ^if_addr[1:0];

  assign req_index  = if_addr[INDEX_BITS+1:2];
  assign req_tag    = if_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign req_hit    = valid_q[req_index] && (tag_q[req_index] == req_tag);

  // The miss address is latched in mc_addr_q, so the fill target comes from there.
  assign fill_index = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag   = mc_addr_q[ADDR_BITS-1:INDEX_BITS+2];

  // clr has priority over a coincident mc_done, so that word is dropped.
  assign fill_en    = rdy && !clr && (state_q == StMiss) && mc_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      if_valid_q <= 1'b0;
      if (clr) begin
        state_q  <= StIdle;
        mc_req_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (if_req) begin
              if (req_hit) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= data_q[req_index];
              end else begin
                state_q   <= StMiss;
                mc_req_q  <= 1'b1;
                mc_addr_q <= {if_addr[ADDR_BITS-1:2], 2'b00};
              end
            end
          end
          StMiss: begin
            if (mc_done) begin
              state_q             <= StIdle;
              mc_req_q            <= 1'b0;
              if_valid_q          <= 1'b1;
              if_inst_q           <= mc_data;
              valid_q[fill_index] <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= mc_data;
    end
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign mc_req   = mc_req_q;
  assign mc_addr  = mc_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  int n_checks = 0;
  int n_bad    = 0;

  inst_cache #(
    .INDEX_BITS(6),
    .ADDR_BITS (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .clr     (clr),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_valid(if_valid),
    .if_inst (if_inst),
    .mc_req  (mc_req),
    .mc_addr (mc_addr),
    .mc_done (mc_done),
    .mc_data (mc_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    rdy     = 1'b1;
    clr     = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    mc_done = 1'b0;
    mc_data = '0;

    #3;
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_inst", if_inst, 32'd0);
    check_eq("rst_mc_req", {31'd0, mc_req}, 32'd0);
    check_eq("rst_mc_addr", mc_addr, 32'd0);
    step();
    step();
    rst = 1'b1;

    // Cold miss on 0x4.
    if_req  = 1'b1;
    if_addr = 32'h4;
    step();
    check_eq("cold_mc_req", {31'd0, mc_req}, 32'd1);
    check_eq("cold_mc_addr", mc_addr, 32'h4);
    check_eq("cold_no_valid", {31'd0, if_valid}, 32'd0);
    if_addr = 32'h200; // ignored while the miss is outstanding
    step();
    step();
    check_eq("cold_hold_addr", mc_addr, 32'h4);
    if_addr = 32'h4;
    mc_done = 1'b1;
    mc_data = 32'h13;
    step();
    check_eq("cold_fill_valid", {31'd0, if_valid}, 32'd1);
    check_eq("cold_fill_inst", if_inst, 32'h13);
    check_eq("cold_fill_mc_req", {31'd0, mc_req}, 32'd0);
    mc_done = 1'b0;
    if_req  = 1'b0;
    step();
    check_eq("valid_one_cycle", {31'd0, if_valid}, 32'd0);

    // Hit on 0x4.
    if_req  = 1'b1;
    if_addr = 32'h4;
    step();
    check_eq("hit_valid", {31'd0, if_valid}, 32'd1);
    check_eq("hit_inst", if_inst, 32'h13);
    check_eq("hit_mc_req", {31'd0, mc_req}, 32'd0);
    if_req = 1'b0;
    step();
    check_eq("hit_pulse_end", {31'd0, if_valid}, 32'd0);

    // Conflict: 0x104 shares index 1 with 0x4.
    if_req  = 1'b1;
    if_addr = 32'h104;
    step();
    check_eq("conf_mc_req", {31'd0, mc_req}, 32'd1);
    check_eq("conf_mc_addr", mc_addr, 32'h104);
    mc_done = 1'b1;
    mc_data = 32'haa;
    step();
    check_eq("conf_fill_inst", if_inst, 32'haa);
    mc_done = 1'b0;
    if_addr = 32'h4;
    step();
    check_eq("evict_mc_req", {31'd0, mc_req}, 32'd1);
    check_eq("evict_mc_addr", mc_addr, 32'h4);
    check_eq("evict_no_valid", {31'd0, if_valid}, 32'd0);
    mc_done = 1'b1;
    mc_data = 32'h13;
    step();
    check_eq("refill_inst", if_inst, 32'h13);
    mc_done = 1'b0;
    if_req  = 1'b0;
    step();
    // Byte offset ignored: 0x7 hits the 0x4 line.
    if_req  = 1'b1;
    if_addr = 32'h7;
    step();
    check_eq("offset_hit_valid", {31'd0, if_valid}, 32'd1);
    check_eq("offset_hit_mc_req", {31'd0, mc_req}, 32'd0);
    if_req = 1'b0;
    step();

    // Flush during a miss on 0x8.
    if_req  = 1'b1;
    if_addr = 32'h8;
    step();
    check_eq("flush_miss_req", {31'd0, mc_req}, 32'd1);
    step();
    clr = 1'b1;
    step();
    check_eq("flush_mc_req", {31'd0, mc_req}, 32'd0);
    check_eq("flush_no_valid", {31'd0, if_valid}, 32'd0);
    clr     = 1'b0;
    if_req  = 1'b0;
    mc_done = 1'b1;
    mc_data = 32'hdead;
    step();
    check_eq("late_done_valid", {31'd0, if_valid}, 32'd0);
    check_eq("late_done_mc_req", {31'd0, mc_req}, 32'd0);
    mc_done = 1'b0;
    if_req  = 1'b1;
    step();
    check_eq("flush_rereq_miss", {31'd0, mc_req}, 32'd1);
    check_eq("flush_rereq_addr", mc_addr, 32'h8);
    mc_done = 1'b1;
    mc_data = 32'h55;
    step();
    check_eq("flush_refill", if_inst, 32'h55);
    mc_done = 1'b0;
    if_req  = 1'b0;
    step();

    // clr and mc_done together on 0xC.
    if_req  = 1'b1;
    if_addr = 32'hc;
    step();
    clr     = 1'b1;
    mc_done = 1'b1;
    mc_data = 32'h77;
    step();
    check_eq("clr_done_valid", {31'd0, if_valid}, 32'd0);
    check_eq("clr_done_mc_req", {31'd0, mc_req}, 32'd0);
    clr     = 1'b0;
    mc_done = 1'b0;
    step();
    check_eq("clr_done_rereq", {31'd0, mc_req}, 32'd1);
    mc_done = 1'b1;
    mc_data = 32'h99;
    step();
    check_eq("clr_done_fill", if_inst, 32'h99);
    mc_done = 1'b0;
    if_req  = 1'b0;
    step();

    // rdy low for 5 cycles mid-miss with mc_done pulsing.
    if_req  = 1'b1;
    if_addr = 32'h10;
    step();
    check_eq("frz_miss_addr", mc_addr, 32'h10);
    rdy     = 1'b0;
    mc_done = 1'b1;
    mc_data = 32'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("frz_mc_req", {31'd0, mc_req}, 32'd1);
      check_eq("frz_if_valid", {31'd0, if_valid}, 32'd0);
      check_eq("frz_if_inst", if_inst, 32'h99);
    end
    rdy     = 1'b1;
    mc_done = 1'b0;
    step();
    check_eq("frz_after_mc_req", {31'd0, mc_req}, 32'd1);

    // Asynchronous reset mid-miss.
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_mc_req", {31'd0, mc_req}, 32'd0);
    check_eq("arst_mc_addr", mc_addr, 32'd0);
    check_eq("arst_if_inst", if_inst, 32'd0);
    check_eq("arst_if_valid", {31'd0, if_valid}, 32'd0);
    step();
    rst     = 1'b1;
    if_req  = 1'b0;
    mc_done = 1'b1;
    mc_data = 32'h2;
    step();
    check_eq("arst_no_fill", {31'd0, if_valid}, 32'd0);
    mc_done = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h4;
    step();
    check_eq("arst_prior_hit_miss", {31'd0, mc_req}, 32'd1);
    check_eq("arst_prior_hit_addr", mc_addr, 32'h4);
    check_eq("arst_prior_hit_novalid", {31'd0, if_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
